// File: rtl/drac_pkg.sv
// Shared types and constants for the data-cache request arbiter.
// Holds the request field bundle, dcache command encodings, tag layout
// and the arbiter FSM state type.
package drac_pkg;

   localparam int ADDR_W             = 40;
   localparam int DATA_W             = 64;
   localparam int CMD_W              = 5;
   localparam int OP_TYPE_W          = 4;
   localparam int DCACHE_TAG_OWNER_W = 2;
   localparam int DCACHE_TAG_SEQ_W   = 6;
   localparam int DCACHE_TAG_W       = DCACHE_TAG_SEQ_W + DCACHE_TAG_OWNER_W;

   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [DATA_W-1:0]    bus64_t;
   typedef logic [CMD_W-1:0]     dcache_cmd_t;
   typedef logic [OP_TYPE_W-1:0] dcache_op_type_t;

   localparam dcache_cmd_t DCMD_LOAD  = 5'h00;
   localparam dcache_cmd_t DCMD_STORE = 5'h01;
   localparam dcache_cmd_t DCMD_LR    = 5'h06;
   localparam dcache_cmd_t DCMD_SC    = 5'h07;
   localparam dcache_cmd_t DCMD_FLUSH = 5'h10;

   typedef struct packed {
      dcache_cmd_t     cmd;
      addr_t           addr;
      dcache_op_type_t op_type;
      bus64_t          data;
   } dcache_req_fields_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dcache_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - highest-priority index for this decision
//   grant     - one-hot grant (all zero when nothing requests)
//   grant_idx - encoded index of the granted requester
module rr_arbiter
   import drac_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]            req,
   input  logic [DCACHE_TAG_OWNER_W-1:0] ptr,
   output logic [NUM_REQ-1:0]            grant,
   output logic [DCACHE_TAG_OWNER_W-1:0] grant_idx
);

   localparam int PAD_W = 1 << DCACHE_TAG_OWNER_W;

   logic [PAD_W-1:0] req_pad;
   logic [PAD_W-1:0] grant_pad;

   function automatic logic [DCACHE_TAG_OWNER_W-1:0] wrap_idx(
      input logic [DCACHE_TAG_OWNER_W-1:0] base,
      input int                            off
   );
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return sum[DCACHE_TAG_OWNER_W-1:0];
   endfunction

   assign req_pad = PAD_W'(req);

   // Walk from the farthest candidate back to ptr so the nearest valid
   // requester is the last one written and therefore wins.
   always_comb begin
      grant_pad = '0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_pad[wrap_idx(ptr, i)]) begin
            grant_pad                    = '0;
            grant_pad[wrap_idx(ptr, i)]  = 1'b1;
            grant_idx                    = wrap_idx(ptr, i);
         end
      end
   end

   assign grant = grant_pad[NUM_REQ-1:0];

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one data-cache request port between NUM_REQ requesters.
// One access in flight; round-robin grant; retries on nack up to
// MAX_RETRY attempts, then returns an error response to the owner.
// Ports:
//   clk_i, rstn_i              - clock, synchronous active-low reset
//   req_*_i / req_ready_o      - per-requester request and accept pulse
//   resp_valid_o/data/error    - per-requester response strobe, shared data
//   dmem_req_*                 - latched request towards the dcache
//   dmem_resp_*                - dcache response / nack
//   busy_o                     - transaction in progress
//
// state    | meaning
// ST_IDLE  | no access in flight; grant any valid requester
// ST_ISSUE | driving dmem_req_valid_o, waiting for dmem_req_ready_i
// ST_WAIT  | request accepted, waiting for response or nack
module dcache_req_arbiter
   import drac_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_RETRY = 4
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*CMD_W-1:0]  req_cmd_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*OP_TYPE_W-1:0] req_op_type_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        resp_valid_o,
   output logic [DATA_W-1:0]         resp_data_o,
   output logic                      resp_error_o,
   output logic                      dmem_req_valid_o,
   input  logic                      dmem_req_ready_i,
   output logic [CMD_W-1:0]          dmem_req_cmd_o,
   output logic [ADDR_W-1:0]         dmem_req_addr_o,
   output logic [OP_TYPE_W-1:0]      dmem_op_type_o,
   output logic [DATA_W-1:0]         dmem_req_data_o,
   output logic [DCACHE_TAG_W-1:0]   dmem_req_tag_o,
   input  logic                      dmem_resp_valid_i,
   input  logic                      dmem_resp_nack_i,
   input  logic [DATA_W-1:0]         dmem_resp_data_i,
   output logic                      busy_o
);

   localparam int OWN_W   = DCACHE_TAG_OWNER_W;
   localparam int SEQ_W   = DCACHE_TAG_SEQ_W;
   localparam int RETRY_W = $clog2(MAX_RETRY) + 1;
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
   localparam logic [OWN_W-1:0]   LAST_IDX   = OWN_W'(NUM_REQ - 1);

   arb_state_t         state_q, state_d;
   dcache_req_fields_t fields_q, sel_fields;
   logic [OWN_W-1:0]   owner_q, rr_ptr_q, grant_idx, next_ptr;
   logic [SEQ_W-1:0]   seq_q;
   logic [RETRY_W-1:0] retry_q;
   logic [NUM_REQ-1:0] grant, resp_valid_q, owner_onehot;
   bus64_t             resp_data_q;
   logic               resp_error_q;
   logic               take, retry, done_ok, done_err;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_fields = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_fields.cmd     = req_cmd_i[i*CMD_W +: CMD_W];
            sel_fields.addr    = req_addr_i[i*ADDR_W +: ADDR_W];
            sel_fields.op_type = req_op_type_i[i*OP_TYPE_W +: OP_TYPE_W];
            sel_fields.data    = req_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      retry    = 1'b0;
      done_ok  = 1'b0;
      done_err = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               take    = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (dmem_req_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // nack has priority over a simultaneous valid
            if (dmem_resp_nack_i) begin
               if (retry_q < RETRY_LAST) begin
                  retry   = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  done_err = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else if (dmem_resp_valid_i) begin
               done_ok = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign next_ptr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
   assign owner_onehot = NUM_REQ'(1) << owner_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= ST_IDLE;
         fields_q     <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         seq_q        <= '0;
         retry_q      <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= '0;
         resp_error_q <= 1'b0;
         if (take) begin
            fields_q <= sel_fields;
            owner_q  <= grant_idx;
            retry_q  <= '0;
         end
         if (retry) retry_q <= retry_q + 1'b1;
         if (done_ok) begin
            resp_valid_q <= owner_onehot;
            resp_data_q  <= dmem_resp_data_i;
            rr_ptr_q     <= next_ptr;
            seq_q        <= seq_q + 1'b1;
         end
         if (done_err) begin
            resp_valid_q <= owner_onehot;
            resp_error_q <= 1'b1;
            resp_data_q  <= '0;
            rr_ptr_q     <= next_ptr;
         end
      end
   end

   // Gated by rstn_i so nothing is accepted in a cycle that is being reset.
   assign req_ready_o      = (take && rstn_i) ? grant : '0;
   assign resp_valid_o     = resp_valid_q;
   assign resp_data_o      = resp_data_q;
   assign resp_error_o     = resp_error_q;
   assign dmem_req_valid_o = (state_q == ST_ISSUE);
   assign dmem_req_cmd_o   = fields_q.cmd;
   assign dmem_req_addr_o  = fields_q.addr;
   assign dmem_op_type_o   = fields_q.op_type;
   assign dmem_req_data_o  = fields_q.data;
   assign dmem_req_tag_o   = {seq_q, owner_q};
   assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dcache_req_arbiter.sv
module tb_dcache_req_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int MAX_RETRY = 4;

   logic                     clk_i = 1'b0;
   logic                     rstn_i;
   logic [NUM_REQ-1:0]       req_valid_i, req_ready_o, resp_valid_o;
   logic [NUM_REQ*5-1:0]     req_cmd_i;
   logic [NUM_REQ*40-1:0]    req_addr_i;
   logic [NUM_REQ*4-1:0]     req_op_type_i;
   logic [NUM_REQ*64-1:0]    req_data_i;
   logic [63:0]              resp_data_o;
   logic                     resp_error_o;
   logic                     dmem_req_valid_o, dmem_req_ready_i;
   logic [4:0]               dmem_req_cmd_o;
   logic [39:0]              dmem_req_addr_o;
   logic [3:0]               dmem_op_type_o;
   logic [63:0]              dmem_req_data_o;
   logic [7:0]               dmem_req_tag_o;
   logic                     dmem_resp_valid_i, dmem_resp_nack_i;
   logic [63:0]              dmem_resp_data_i;
   logic                     busy_o;

   always #5 clk_i = ~clk_i;

   dcache_req_arbiter #(.NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY)) dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_cmd_i         (req_cmd_i),
      .req_addr_i        (req_addr_i),
      .req_op_type_i     (req_op_type_i),
      .req_data_i        (req_data_i),
      .resp_valid_o      (resp_valid_o),
      .resp_data_o       (resp_data_o),
      .resp_error_o      (resp_error_o),
      .dmem_req_valid_o  (dmem_req_valid_o),
      .dmem_req_ready_i  (dmem_req_ready_i),
      .dmem_req_cmd_o    (dmem_req_cmd_o),
      .dmem_req_addr_o   (dmem_req_addr_o),
      .dmem_op_type_o    (dmem_op_type_o),
      .dmem_req_data_o   (dmem_req_data_o),
      .dmem_req_tag_o    (dmem_req_tag_o),
      .dmem_resp_valid_i (dmem_resp_valid_i),
      .dmem_resp_nack_i  (dmem_resp_nack_i),
      .dmem_resp_data_i  (dmem_resp_data_i),
      .busy_o            (busy_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: round-robin pointer, sequence number, requester fields
   int                 m_ptr, m_seq;
   logic [4:0]         f_cmd  [NUM_REQ];
   logic [39:0]        f_addr [NUM_REQ];
   logic [3:0]         f_op   [NUM_REQ];
   logic [63:0]        f_data [NUM_REQ];
   bit                 pend;
   logic [NUM_REQ-1:0] pend_vec;
   bit                 pend_err;
   logic [63:0]        pend_data;
   logic [NUM_REQ-1:0] rand_v;
   int                 rand_nack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
      for (int i = 0; i < NUM_REQ; i++)
         if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
      return -1;
   endfunction

   task automatic new_fields;
      for (int i = 0; i < NUM_REQ; i++) begin
         f_cmd[i]  = 5'($urandom_range(0, 31));
         f_addr[i] = {8'($urandom), $urandom};
         f_op[i]   = 4'($urandom_range(0, 15));
         f_data[i] = {$urandom, $urandom};
         req_cmd_i[i*5 +: 5]      = f_cmd[i];
         req_addr_i[i*40 +: 40]   = f_addr[i];
         req_op_type_i[i*4 +: 4]  = f_op[i];
         req_data_i[i*64 +: 64]   = f_data[i];
      end
   endtask

   task automatic check_resp_slot;
      if (pend) begin
         chk("resp_valid", resp_valid_o, pend_vec);
         chk("resp_error", resp_error_o, pend_err);
         chk("resp_data", resp_data_o, pend_data);
         pend = 0;
      end else begin
         chk("resp_quiet", resp_valid_o, 0);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_req_ready"}, req_ready_o, 0);
      chk({pfx, "_resp_valid"}, resp_valid_o, 0);
      chk({pfx, "_resp_data"}, resp_data_o, 0);
      chk({pfx, "_resp_error"}, resp_error_o, 0);
      chk({pfx, "_dmem_valid"}, dmem_req_valid_o, 0);
      chk({pfx, "_dmem_cmd"}, dmem_req_cmd_o, 0);
      chk({pfx, "_dmem_addr"}, dmem_req_addr_o, 0);
      chk({pfx, "_dmem_op"}, dmem_op_type_o, 0);
      chk({pfx, "_dmem_data"}, dmem_req_data_o, 0);
      chk({pfx, "_dmem_tag"}, dmem_req_tag_o, 0);
      chk({pfx, "_busy"}, busy_o, 0);
   endtask

   // One whole transaction, entered just after a clock edge with the DUT in
   // IDLE; returns just after the edge where the response becomes visible.
   task automatic do_txn(input logic [NUM_REQ-1:0] valids, input int ready_dly,
                         input int n_nack, input bit nack_with_valid,
                         input int wait_dly, input logic [63:0] rdata,
                         input bit rst_in_wait);
      int         w;
      logic [7:0] tag;
      new_fields();
      req_valid_i = valids;
      #1;
      check_resp_slot();
      chk("busy_idle", busy_o, 0);
      w = pick(valids, m_ptr);
      chk("grant", req_ready_o, NUM_REQ'(1) << w);
      tag = {6'(m_seq), 2'(w)};
      tick();
      for (int a = 0; a <= n_nack; a++) begin
         for (int d = 0; d <= ready_dly; d++) begin
            req_valid_i      = NUM_REQ'($urandom);
            dmem_req_ready_i = (d == ready_dly);
            #1;
            chk("issue_valid", dmem_req_valid_o, 1);
            chk("issue_tag", dmem_req_tag_o, tag);
            chk("issue_cmd", dmem_req_cmd_o, f_cmd[w]);
            chk("issue_addr", dmem_req_addr_o, f_addr[w]);
            chk("issue_op", dmem_op_type_o, f_op[w]);
            chk("issue_data", dmem_req_data_o, f_data[w]);
            chk("no_grant_busy", req_ready_o, 0);
            chk("no_resp_busy", resp_valid_o, 0);
            chk("busy_issue", busy_o, 1);
            tick();
         end
         dmem_req_ready_i = 1'b0;
         if (rst_in_wait) begin
            rstn_i            = 1'b0;
            dmem_resp_valid_i = 1'b1;
            dmem_resp_data_i  = rdata;
            tick();
            rstn_i            = 1'b1;
            dmem_resp_valid_i = 1'b0;
            req_valid_i       = '0;
            #1;
            check_all_zero("rst_wait");
            tick();
            #1;
            chk("rst_no_late_resp", resp_valid_o, 0);
            tick();
            m_ptr = 0;
            m_seq = 0;
            pend  = 0;
            return;
         end
         for (int d = 0; d < wait_dly; d++) begin
            #1;
            chk("wait_no_dmem_valid", dmem_req_valid_o, 0);
            chk("wait_no_resp", resp_valid_o, 0);
            tick();
         end
         dmem_resp_data_i = rdata;
         if (a < n_nack) begin
            dmem_resp_nack_i  = 1'b1;
            dmem_resp_valid_i = nack_with_valid;
            tick();
            dmem_resp_nack_i  = 1'b0;
            dmem_resp_valid_i = 1'b0;
            if (a == MAX_RETRY - 1) begin
               pend      = 1;
               pend_vec  = NUM_REQ'(1) << w;
               pend_err  = 1;
               pend_data = '0;
               m_ptr     = (w + 1) % NUM_REQ;
               break;
            end
         end else begin
            dmem_resp_valid_i = 1'b1;
            tick();
            dmem_resp_valid_i = 1'b0;
            pend      = 1;
            pend_vec  = NUM_REQ'(1) << w;
            pend_err  = 0;
            pend_data = rdata;
            m_ptr     = (w + 1) % NUM_REQ;
            m_seq     = (m_seq + 1) % 64;
         end
      end
   endtask

   initial begin
      rstn_i            = 1'b0;
      req_valid_i       = '1;
      req_cmd_i         = '0;
      req_addr_i        = '0;
      req_op_type_i     = '0;
      req_data_i        = '0;
      dmem_req_ready_i  = 1'b0;
      dmem_resp_valid_i = 1'b0;
      dmem_resp_nack_i  = 1'b0;
      dmem_resp_data_i  = '0;
      m_ptr = 0;
      m_seq = 0;
      pend  = 0;
      tick();
      tick();
      #1;
      check_all_zero("reset");
      rstn_i      = 1'b1;
      req_valid_i = '0;
      tick();

      // single requester, response two cycles after acceptance
      do_txn(2'b01, 0, 0, 0, 1, 64'hDEADBEEF, 0);
      // contention: both valid, expect alternating owners
      repeat (4) do_txn(2'b11, 0, 0, 0, 0, {$urandom, $urandom}, 0);
      // backpressure for 5 cycles, two nacks with valid asserted alongside
      do_txn(2'b10, 5, 2, 1, 1, {$urandom, $urandom}, 0);
      // retry budget exhausted
      do_txn(2'b01, 1, MAX_RETRY, 0, 0, {$urandom, $urandom}, 0);
      // reset while waiting for the response, then restart from req0/seq 0
      do_txn(2'b11, 0, 0, 0, 0, {$urandom, $urandom}, 1);
      do_txn(2'b11, 0, 0, 0, 0, {$urandom, $urandom}, 0);

      // random traffic, long enough to wrap the sequence number
      for (int n = 0; n < 90; n++) begin
         do rand_v = NUM_REQ'($urandom); while (rand_v == '0);
         rand_nack = ($urandom_range(0, 7) == 0) ? MAX_RETRY : int'($urandom_range(0, 2));
         do_txn(rand_v, $urandom_range(0, 3), rand_nack, 1'($urandom),
                $urandom_range(0, 2), {$urandom, $urandom}, 0);
      end

      req_valid_i = '0;
      #1;
      check_resp_slot();
      chk("final_busy", busy_o, 0);
      chk("final_no_grant", req_ready_o, 0);
      tick();
      #1;
      chk("final_quiet", resp_valid_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
